if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//   Instruction-fetch stage placed directly upstream of the combinational IMem.
//   Owns the PC, drives imem_addr, captures the returned word into a small fetch
//   queue, and presents {instr, pc, pc+4} to decode through a valid/ready handshake.
//   Branch/jump redirects from later stages flush the queue and reload the PC.
// PARAMETERS
//   RESET_PC  32'h0000_0000  PC value loaded on reset
//   QDEPTH    2              fetch-queue entries; power of 2, >= 2
// PORTS
//   clk             in   1   clock, rising edge
//   rst             in   1   asynchronous, active-high reset
//   imem_addr       out  32  byte address to IMem (= current PC)
//   imem_instr      in   32  instruction from IMem, combinational in imem_addr
//   redirect_valid  in   1   flush and load redirect_pc this cycle
//   redirect_pc     in   32  new fetch address (bits [1:0] ignored)
//   id_valid        out  1   queue head holds a valid instruction
//   id_ready        in   1   decode accepts head this cycle
//   id_instr        out  32  head instruction word
//   id_pc           out  32  PC of head instruction
//   id_pc_plus4     out  32  id_pc + 4, modulo 2^32
// BEHAVIOUR
// - Reset (async, rst=1): pc<=RESET_PC, count<=0, rd/wr pointers<=0; id_valid=0;
//   id_instr, id_pc and id_pc_plus4 read 0 while the queue is empty.
// - imem_addr = pc at all times, including while stalled.
// - pop  = id_valid & id_ready.
// - push = ~redirect_valid & (count<QDEPTH | pop).
// - Push writes {imem_instr, pc} at wr_ptr and sets pc<=pc+4.
// - Latency: a word fetched in cycle N is on id_* in cycle N+1 (registered queue).
// - Full with no pop: no push; pc holds; imem_addr stable.
// - Full with pop: push and pop in the same cycle; count unchanged; throughput 1/cycle.
// - Empty with push: id_valid rises next cycle. Data never bypasses the queue combinationally.
// - Redirect has top priority:
//   - count<=0, pointers<=0, pc<={redirect_pc[31:2],2'b00}, no push.
//   - A head popped in the same cycle still counts as consumed by decode; all other
//     entries are discarded.
//   - Next cycle: id_valid=0, imem_addr=new pc. Cycle after: redirect target on id_*.
// - Back-to-back redirects: the last one wins. Each redirect restarts the sequence.
// - PC arithmetic is 32-bit unsigned and wraps: 32'hFFFF_FFFC + 4 -> 32'h0000_0000.
// - count width is clog2(QDEPTH)+1; pointers wrap modulo QDEPTH.
// - No state machine beyond the PC and queue; all state is reset asynchronously.
// CONFIGURATION
//   FETCH_STATS_EN defined:
//     - Adds port fetch_count (out, 32): number of pushes since reset.
//     - Reset value 0; +1 on each push; wraps at 2^32.
//     - Redirects do not decrement it.
//   FETCH_STATS_EN undefined:
//     - fetch_count port and its counter are absent.
//     - All other behaviour is identical.
// TESTING
// 1. Reset with RESET_PC=0, id_ready=1, 4 cycles -> imem_addr 0,4,8,C;
//    id_pc 0,4,8 from cycle 2 on; id_valid=0 in cycle 1.
// 2. Hold id_ready=0 from reset -> count saturates at QDEPTH=2; imem_addr holds 8;
//    id_pc stays 0. Raise id_ready -> id_pc 0,4,8 on consecutive cycles.
// 3. Queue full, redirect_valid=1 with redirect_pc=32'h0000_0103 -> next cycle
//    id_valid=0 and imem_addr=32'h100; following cycle id_pc=32'h100,
//    id_pc_plus4=32'h104.
// 4. redirect_valid=1 and pop in the same cycle -> popped head counted consumed;
//    no stale entry ever appears on id_*.
// 5. redirect_pc=32'hFFFF_FFFC, id_ready=1 -> id_pc FFFF_FFFC then 0000_0000;
//    id_pc_plus4 for FFFF_FFFC reads 0.
// 6. FETCH_STATS_EN defined, 10 cycles with id_ready=1 after reset -> fetch_count=10;
//    assert rst mid-run -> fetch_count=0 and id_valid=0 immediately.

Source files
------------

// File: rtl/if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : if_fetch_unit
// Description : Instruction-fetch stage in front of a combinational IMem.
//               Owns the PC, drives imem_addr, and captures each fetched
//               word with its PC into a small registered queue. The queue
//               head is offered to decode as {instr, pc, pc+4} through a
//               valid/ready handshake. A redirect flushes the queue and
//               reloads the PC.
// Ports       : clk, rst (async, active-high)
//               imem_addr  (out 32)  / imem_instr (in 32)
//               redirect_valid, redirect_pc (in)
//               id_valid, id_instr, id_pc, id_pc_plus4 (out), id_ready (in)
//               fetch_count (out 32, only when FETCH_STATS_EN is defined)
// Options     : FETCH_STATS_EN - adds a free-running push counter port.
// Revision    : 1.0 - initial release
// ============================================================================
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QDEPTH   = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        id_valid,
    input  logic        id_ready,
    output logic [31:0] id_instr,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0] fetch_count
`else
`endif
);

    localparam int               c_ptr_w     = $clog2(QDEPTH);
    localparam int               c_cnt_w     = c_ptr_w + 1;
    localparam logic [c_ptr_w-1:0] c_ptr_one = c_ptr_w'(1);
    localparam logic [c_cnt_w-1:0] c_cnt_one = c_cnt_w'(1);
    localparam logic [c_cnt_w-1:0] c_depth   = c_cnt_w'(QDEPTH);
    localparam logic [31:0]      c_align_mask = 32'hFFFF_FFFC;

    logic [31:0]        r_pc;
    logic [c_cnt_w-1:0] r_count;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [31:0]        r_q_instr [QDEPTH];
    logic [31:0]        r_q_pc    [QDEPTH];

    logic w_pop;
    logic w_push;

    assign imem_addr = r_pc;
    assign id_valid  = (r_count != '0);

    // A pop that coincides with a redirect is still a real handoff to decode;
    // only the surviving entries are dropped.
    assign w_pop  = id_valid & id_ready;
    assign w_push = ~redirect_valid & ((r_count < c_depth) | w_pop);

    // Outputs are forced to zero while empty so stale queue contents never leak.
    assign id_instr    = id_valid ? r_q_instr[r_rd_ptr]       : 32'h0;
    assign id_pc       = id_valid ? r_q_pc[r_rd_ptr]          : 32'h0;
    assign id_pc_plus4 = id_valid ? (r_q_pc[r_rd_ptr] + 32'd4) : 32'h0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            for (int i = 0; i < QDEPTH; i++) begin
                r_q_instr[i] <= 32'h0;
                r_q_pc[i]    <= 32'h0;
            end
        end else if (redirect_valid) begin
            r_pc     <= redirect_pc & c_align_mask;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            if (w_push) begin
                r_q_instr[r_wr_ptr] <= imem_instr;
                r_q_pc[r_wr_ptr]    <= r_pc;
                r_wr_ptr            <= r_wr_ptr + c_ptr_one;
                r_pc                <= r_pc + 32'd4;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_cnt_one;
                2'b01:   r_count <= r_count - c_cnt_one;
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef FETCH_STATS_EN
    logic [31:0] r_fetch_count;

    // Counts pushes only; a flush does not take anything back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_count <= 32'h0;
        end else if (w_push) begin
            r_fetch_count <= r_fetch_count + 32'd1;
        end
    end

    assign fetch_count = r_fetch_count;
`else
    // Statistics counter not built in this configuration.
`endif

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_fetch_unit
// Description : Directed self-checking bench for if_fetch_unit. The IMem is
//               modelled as instr = addr ^ 32'hDEAD_0000 so each word is
//               traceable to its fetch address.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_fetch_unit;

    localparam logic [31:0] c_tag = 32'hDEAD_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr;
    logic [31:0] imem_instr;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc;
    logic [31:0] id_pc_plus4;
`ifdef FETCH_STATS_EN
    logic [31:0] fetch_count;
`endif

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign imem_instr = imem_addr ^ c_tag;

    if_fetch_unit #(
        .RESET_PC (32'h0000_0000),
        .QDEPTH   (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_instr       (id_instr),
        .id_pc          (id_pc),
        .id_pc_plus4    (id_pc_plus4)
`ifdef FETCH_STATS_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    // Inputs change 1 time unit after the rising edge; checks happen at the
    // falling edge in the middle of the cycle.
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench at the start of "cycle 1" (first cycle out of reset).
    task automatic do_reset(input logic ready);
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = ready;
        next_cycle();
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        id_ready       = 1'b1;
        @(negedge clk);
        n_total++; if (id_valid !== 1'b0) $display("FAIL rst_valid got %b exp 0", id_valid); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL rst_addr got %h exp 00000000", imem_addr); else n_pass++;
        n_total++; if (id_pc !== 32'h0) $display("FAIL rst_id_pc got %h exp 00000000", id_pc); else n_pass++;
        n_total++; if (id_instr !== 32'h0) $display("FAIL rst_id_instr got %h exp 00000000", id_instr); else n_pass++;
        n_total++; if (id_pc_plus4 !== 32'h0) $display("FAIL rst_pc4 got %h exp 00000000", id_pc_plus4); else n_pass++;
    endtask

    task automatic test_stream();
        logic [31:0] exp_pc;
        do_reset(1'b1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_total++; if (imem_addr !== 32'(4 * i)) $display("FAIL stream_addr[%0d] got %h exp %h", i, imem_addr, 32'(4 * i)); else n_pass++;
            if (i == 0) begin
                n_total++; if (id_valid !== 1'b0) $display("FAIL stream_valid0 got %b exp 0", id_valid); else n_pass++;
            end else begin
                exp_pc = 32'(4 * (i - 1));
                n_total++; if (id_valid !== 1'b1) $display("FAIL stream_valid[%0d] got %b exp 1", i, id_valid); else n_pass++;
                n_total++; if (id_pc !== exp_pc) $display("FAIL stream_pc[%0d] got %h exp %h", i, id_pc, exp_pc); else n_pass++;
                n_total++; if (id_instr !== (exp_pc ^ c_tag)) $display("FAIL stream_instr[%0d] got %h exp %h", i, id_instr, exp_pc ^ c_tag); else n_pass++;
                n_total++; if (id_pc_plus4 !== exp_pc + 32'd4) $display("FAIL stream_pc4[%0d] got %h exp %h", i, id_pc_plus4, exp_pc + 32'd4); else n_pass++;
            end
            next_cycle();
        end
    endtask

    task automatic test_stall();
        logic [31:0] exp_pc;
        do_reset(1'b0);
        next_cycle();                 // cycle 1: first push
        next_cycle();                 // cycle 2: second push, queue becomes full
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++; if (imem_addr !== 32'h8) $display("FAIL stall_addr[%0d] got %h exp 00000008", i, imem_addr); else n_pass++;
            n_total++; if (id_pc !== 32'h0) $display("FAIL stall_pc[%0d] got %h exp 00000000", i, id_pc); else n_pass++;
            n_total++; if (id_valid !== 1'b1) $display("FAIL stall_valid[%0d] got %b exp 1", i, id_valid); else n_pass++;
            next_cycle();
        end
        id_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(4 * i);
            @(negedge clk);
            n_total++; if (id_pc !== exp_pc) $display("FAIL drain_pc[%0d] got %h exp %h", i, id_pc, exp_pc); else n_pass++;
            n_total++; if (id_instr !== (exp_pc ^ c_tag)) $display("FAIL drain_instr[%0d] got %h exp %h", i, id_instr, exp_pc ^ c_tag); else n_pass++;
            n_total++; if (imem_addr !== exp_pc + 32'd8) $display("FAIL drain_addr[%0d] got %h exp %h", i, imem_addr, exp_pc + 32'd8); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_redirect_full();
        do_reset(1'b0);
        next_cycle();
        next_cycle();                 // queue full here
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (id_valid !== 1'b0) $display("FAIL redir_valid got %b exp 0", id_valid); else n_pass++;
        n_total++; if (imem_addr !== 32'h100) $display("FAIL redir_addr got %h exp 00000100", imem_addr); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if (id_valid !== 1'b1) $display("FAIL redir_valid2 got %b exp 1", id_valid); else n_pass++;
        n_total++; if (id_pc !== 32'h100) $display("FAIL redir_pc got %h exp 00000100", id_pc); else n_pass++;
        n_total++; if (id_pc_plus4 !== 32'h104) $display("FAIL redir_pc4 got %h exp 00000104", id_pc_plus4); else n_pass++;
        n_total++; if (id_instr !== (32'h100 ^ c_tag)) $display("FAIL redir_instr got %h exp %h", id_instr, 32'h100 ^ c_tag); else n_pass++;
    endtask

    task automatic test_redirect_pop();
        do_reset(1'b0);
        next_cycle();
        next_cycle();                 // queue holds pc 0 and pc 4
        id_ready       = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        @(negedge clk);
        n_total++; if (id_pc !== 32'h0) $display("FAIL rpop_head got %h exp 00000000", id_pc); else n_pass++;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (id_valid !== 1'b0) $display("FAIL rpop_valid got %b exp 0", id_valid); else n_pass++;
        n_total++; if (imem_addr !== 32'h200) $display("FAIL rpop_addr got %h exp 00000200", imem_addr); else n_pass++;
        next_cycle();
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_total++; if (id_pc !== 32'(32'h200 + 4 * i)) $display("FAIL rpop_pc[%0d] got %h exp %h", i, id_pc, 32'(32'h200 + 4 * i)); else n_pass++;
            n_total++; if (id_valid !== 1'b1) $display("FAIL rpop_v[%0d] got %b exp 1", i, id_valid); else n_pass++;
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        next_cycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        next_cycle();
        redirect_pc    = 32'h0000_0402;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (id_valid !== 1'b0) $display("FAIL b2b_valid got %b exp 0", id_valid); else n_pass++;
        n_total++; if (imem_addr !== 32'h400) $display("FAIL b2b_addr got %h exp 00000400", imem_addr); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if (id_pc !== 32'h400) $display("FAIL b2b_pc got %h exp 00000400", id_pc); else n_pass++;
        next_cycle();
    endtask

    task automatic test_wrap();
        do_reset(1'b1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        next_cycle();
        redirect_valid = 1'b0;
        @(negedge clk);
        n_total++; if (imem_addr !== 32'hFFFF_FFFC) $display("FAIL wrap_addr got %h exp fffffffc", imem_addr); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if (id_pc !== 32'hFFFF_FFFC) $display("FAIL wrap_pc0 got %h exp fffffffc", id_pc); else n_pass++;
        n_total++; if (id_pc_plus4 !== 32'h0) $display("FAIL wrap_pc4 got %h exp 00000000", id_pc_plus4); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL wrap_addr2 got %h exp 00000000", imem_addr); else n_pass++;
        next_cycle();
        @(negedge clk);
        n_total++; if (id_pc !== 32'h0) $display("FAIL wrap_pc1 got %h exp 00000000", id_pc); else n_pass++;
        n_total++; if (id_pc_plus4 !== 32'h4) $display("FAIL wrap_pc41 got %h exp 00000004", id_pc_plus4); else n_pass++;
        next_cycle();
    endtask

    task automatic test_async_reset();
        do_reset(1'b1);
        for (int i = 0; i < 10; i++) next_cycle();
        @(negedge clk);
        n_total++; if (imem_addr !== 32'd40) $display("FAIL run_addr got %h exp 00000028", imem_addr); else n_pass++;
`ifdef FETCH_STATS_EN
        n_total++; if (fetch_count !== 32'd10) $display("FAIL stats_count got %0d exp 10", fetch_count); else n_pass++;
`endif
        #1;
        rst = 1'b1;                   // mid-cycle, away from any clock edge
        #1;
        n_total++; if (id_valid !== 1'b0) $display("FAIL arst_valid got %b exp 0", id_valid); else n_pass++;
        n_total++; if (imem_addr !== 32'h0) $display("FAIL arst_addr got %h exp 00000000", imem_addr); else n_pass++;
        n_total++; if (id_pc !== 32'h0) $display("FAIL arst_pc got %h exp 00000000", id_pc); else n_pass++;
`ifdef FETCH_STATS_EN
        n_total++; if (fetch_count !== 32'd0) $display("FAIL stats_rst got %0d exp 0", fetch_count); else n_pass++;
`endif
        next_cycle();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_stall();
        test_redirect_full();
        test_redirect_pop();
        test_back_to_back();
        test_wrap();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
